simple_bus_arbiter: RTL and testbench

Two-to-one arbiter between the core's instruction-fetch (icache) and data (dcache) simple-bus master ports and a single memory-side simple-bus port. Commands from both masters are merged onto one memory port. Every memory response is routed back, in order, to the master that issued the matching command. It sits directly downstream of DandRiscvSimple and in front of the memory model or the AXI bridge.

---
 rtl/simple_bus_pkg.sv | 24 ++
 rtl/simple_bus_pending_fifo.sv | 50 +++++
 rtl/simple_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_simple_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_bus_pkg.sv
// simple_bus_pkg: shared types for the two-master simple-bus arbiter.
// Holds the master-source enum, the pending-response record and the
// memory data width used by the arbiter and its pending FIFO.
package simple_bus_pkg;

  localparam int MEM_DATA_W = 64;

  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_DCACHE = 1'b1
  } bus_src_e;

  // One outstanding memory command: who issued it and which 32-bit half
  // of the 64-bit response an instruction fetch wants.
  typedef struct packed {
    bus_src_e src;
    logic     addr2;
  } pending_entry_t;

  function automatic bus_src_e other_src(input bus_src_e s);
    return (s == SRC_ICACHE) ? SRC_DCACHE : SRC_ICACHE;
  endfunction

endpackage

// File: rtl/simple_bus_pending_fifo.sv
// simple_bus_pending_fifo: in-order record of commands accepted by memory
// but not yet answered. Pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate counter.
module simple_bus_pending_fifo
  import simple_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  pending_entry_t push_entry,
  input  logic           pop,
  output pending_entry_t head,
  output logic           full,
  output logic           empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;
  pending_entry_t mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers; reset discards every outstanding entry.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, independent of block ordering.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers alone define which entries
    // are valid, so clearing the array would only cost reset fan-out.
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter: merges icache and dcache simple-bus commands onto one
// memory port and routes each in-order memory response back to its issuer.
// Build option: define SIMPLE_BUS_ARB_RR_EN for round-robin arbitration;
// otherwise dcache wins every tie and no priority pointer exists.
module simple_bus_arbiter
  import simple_bus_pkg::*;
#(
  parameter int PENDING_DEPTH = 4,
  parameter int ADDR_W        = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_cmd_valid,
  output logic                  icache_cmd_ready,
  input  logic [ADDR_W-1:0]     icache_cmd_payload_addr,
  output logic                  icache_rsp_valid,
  output logic [31:0]           icache_rsp_payload_data,
  input  logic                  dcache_cmd_valid,
  output logic                  dcache_cmd_ready,
  input  logic [ADDR_W-1:0]     dcache_cmd_payload_addr,
  input  logic                  dcache_cmd_payload_wen,
  input  logic [63:0]           dcache_cmd_payload_wdata,
  input  logic [7:0]            dcache_cmd_payload_wstrb,
  input  logic [2:0]            dcache_cmd_payload_size,
  output logic                  dcache_rsp_valid,
  output logic [MEM_DATA_W-1:0] dcache_rsp_payload_data,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic [ADDR_W-1:0]     mem_cmd_payload_addr,
  output logic                  mem_cmd_payload_wen,
  output logic [63:0]           mem_cmd_payload_wdata,
  output logic [7:0]            mem_cmd_payload_wstrb,
  output logic [2:0]            mem_cmd_payload_size,
  input  logic                  mem_rsp_valid,
  input  logic [MEM_DATA_W-1:0] mem_rsp_payload_data,
  output logic                  err_spurious_rsp
);

  bus_src_e       grant;
  bus_src_e       prio_src;
  bus_src_e       lock_src_q;
  logic           lock_q;
  logic           req_valid;
  logic           cmd_open;
  logic           fire;
  logic           bypass;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic           rsp_route;
  pending_entry_t head;
  pending_entry_t fire_entry;
  pending_entry_t rsp_entry;

`ifdef SIMPLE_BUS_ARB_RR_EN
  bus_src_e rr_q;
  assign prio_src = rr_q;

  // Round-robin pointer: after each fire, the other master gets priority.
  always_ff @(posedge clk) begin
    if (reset)     rr_q <= SRC_ICACHE;
    else if (fire) rr_q <= other_src(grant);
  end
`else
  assign prio_src = SRC_DCACHE;
`endif

  // Grant selection: a stalled command keeps its grant until it fires.
  always_comb begin
    // NOTE: default first so every path assigns grant and no latch forms.
    grant = SRC_ICACHE;
    if (lock_q)                                     grant = lock_src_q;
    else if (icache_cmd_valid && dcache_cmd_valid)  grant = prio_src;
    else if (dcache_cmd_valid)                      grant = SRC_DCACHE;
  end

  assign req_valid        = (grant == SRC_ICACHE) ? icache_cmd_valid : dcache_cmd_valid;
  assign cmd_open         = !reset && !full;
  assign mem_cmd_valid    = cmd_open && req_valid;
  assign icache_cmd_ready = cmd_open && mem_cmd_ready && (grant == SRC_ICACHE) && icache_cmd_valid;
  assign dcache_cmd_ready = cmd_open && mem_cmd_ready && (grant == SRC_DCACHE) && dcache_cmd_valid;
  assign fire             = mem_cmd_valid && mem_cmd_ready;

  // Command payload mux; fetches are fixed 32-bit reads.
  always_comb begin
    mem_cmd_payload_addr  = dcache_cmd_payload_addr;
    mem_cmd_payload_wen   = dcache_cmd_payload_wen;
    mem_cmd_payload_wdata = dcache_cmd_payload_wdata;
    mem_cmd_payload_wstrb = dcache_cmd_payload_wstrb;
    mem_cmd_payload_size  = dcache_cmd_payload_size;
    if (grant == SRC_ICACHE) begin
      mem_cmd_payload_addr  = icache_cmd_payload_addr;
      mem_cmd_payload_wen   = 1'b0;
      mem_cmd_payload_wdata = '0;
      mem_cmd_payload_wstrb = '0;
      mem_cmd_payload_size  = 3'd2;
    end
  end

  // Pending bookkeeping: a response in the fire cycle with nothing queued
  // is answered directly and never enters the FIFO.
  assign fire_entry = '{src: grant, addr2: mem_cmd_payload_addr[2]};
  assign bypass     = empty && fire && mem_rsp_valid;
  assign push       = fire && !bypass;
  assign pop        = mem_rsp_valid && !empty;

  simple_bus_pending_fifo #(
    .DEPTH (PENDING_DEPTH)
  ) u_pending (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (fire_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  // Response routing.
  assign rsp_entry               = bypass ? fire_entry : head;
  assign rsp_route               = !reset && mem_rsp_valid && (!empty || fire);
  assign icache_rsp_valid        = rsp_route && (rsp_entry.src == SRC_ICACHE);
  assign dcache_rsp_valid        = rsp_route && (rsp_entry.src == SRC_DCACHE);
  assign icache_rsp_payload_data = rsp_entry.addr2 ? mem_rsp_payload_data[63:32]
                                                   : mem_rsp_payload_data[31:0];
  assign dcache_rsp_payload_data = mem_rsp_payload_data;

  // Lock register: remember the grant while memory back-pressures a command.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_ICACHE;
    end else begin
      lock_q     <= mem_cmd_valid && !mem_cmd_ready;
      lock_src_q <= grant;
    end
  end

  // Sticky flag for a response that has no command to match.
  always_ff @(posedge clk) begin
    if (reset)                                      err_spurious_rsp <= 1'b0;
    else if (mem_rsp_valid && empty && !fire)       err_spurious_rsp <= 1'b1;
  end

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb_simple_bus_arbiter: directed vector table plus hand-written multi-cycle
// sequences for arbitration, lock, full FIFO and reset behaviour.
module tb_simple_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_cmd_valid;
  logic        icache_cmd_ready;
  logic [63:0] icache_cmd_payload_addr;
  logic        icache_rsp_valid;
  logic [31:0] icache_rsp_payload_data;
  logic        dcache_cmd_valid;
  logic        dcache_cmd_ready;
  logic [63:0] dcache_cmd_payload_addr;
  logic        dcache_cmd_payload_wen;
  logic [63:0] dcache_cmd_payload_wdata;
  logic [7:0]  dcache_cmd_payload_wstrb;
  logic [2:0]  dcache_cmd_payload_size;
  logic        dcache_rsp_valid;
  logic [63:0] dcache_rsp_payload_data;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic [63:0] mem_cmd_payload_addr;
  logic        mem_cmd_payload_wen;
  logic [63:0] mem_cmd_payload_wdata;
  logic [7:0]  mem_cmd_payload_wstrb;
  logic [2:0]  mem_cmd_payload_size;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_payload_data;
  logic        err_spurious_rsp;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  simple_bus_arbiter #(
    .PENDING_DEPTH (4),
    .ADDR_W        (64)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .icache_cmd_valid         (icache_cmd_valid),
    .icache_cmd_ready         (icache_cmd_ready),
    .icache_cmd_payload_addr  (icache_cmd_payload_addr),
    .icache_rsp_valid         (icache_rsp_valid),
    .icache_rsp_payload_data  (icache_rsp_payload_data),
    .dcache_cmd_valid         (dcache_cmd_valid),
    .dcache_cmd_ready         (dcache_cmd_ready),
    .dcache_cmd_payload_addr  (dcache_cmd_payload_addr),
    .dcache_cmd_payload_wen   (dcache_cmd_payload_wen),
    .dcache_cmd_payload_wdata (dcache_cmd_payload_wdata),
    .dcache_cmd_payload_wstrb (dcache_cmd_payload_wstrb),
    .dcache_cmd_payload_size  (dcache_cmd_payload_size),
    .dcache_rsp_valid         (dcache_rsp_valid),
    .dcache_rsp_payload_data  (dcache_rsp_payload_data),
    .mem_cmd_valid            (mem_cmd_valid),
    .mem_cmd_ready            (mem_cmd_ready),
    .mem_cmd_payload_addr     (mem_cmd_payload_addr),
    .mem_cmd_payload_wen      (mem_cmd_payload_wen),
    .mem_cmd_payload_wdata    (mem_cmd_payload_wdata),
    .mem_cmd_payload_wstrb    (mem_cmd_payload_wstrb),
    .mem_cmd_payload_size     (mem_cmd_payload_size),
    .mem_rsp_valid            (mem_rsp_valid),
    .mem_rsp_payload_data     (mem_rsp_payload_data),
    .err_spurious_rsp         (err_spurious_rsp)
  );

  typedef struct {
    logic        ic_v;
    logic [63:0] ic_a;
    logic        dc_v;
    logic [63:0] dc_a;
    logic        dc_wen;
    logic [2:0]  dc_size;
    logic        mready;
    logic        rsp_v;
    logic [63:0] rsp_d;
    logic        e_mvalid;
    logic [63:0] e_maddr;
    logic        e_mwen;
    logic [2:0]  e_msize;
    logic        e_ic_rdy;
    logic        e_dc_rdy;
    logic        e_ic_rv;
    logic [31:0] e_ic_rd;
    logic        e_dc_rv;
    logic [63:0] e_dc_rd;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ic_v, input logic [63:0] ic_a,
                        input logic dc_v, input logic [63:0] dc_a,
                        input logic dc_wen, input logic mready,
                        input logic rsp_v, input logic [63:0] rsp_d);
    icache_cmd_valid         = ic_v;
    icache_cmd_payload_addr  = ic_a;
    dcache_cmd_valid         = dc_v;
    dcache_cmd_payload_addr  = dc_a;
    dcache_cmd_payload_wen   = dc_wen;
    dcache_cmd_payload_size  = 3'd3;
    mem_cmd_ready            = mready;
    mem_rsp_valid            = rsp_v;
    mem_rsp_payload_data     = rsp_d;
  endtask

  task automatic chk_ctl(input string tag, input logic e_mvalid, input logic e_ic_rdy,
                         input logic e_dc_rdy, input logic e_ic_rv, input logic e_dc_rv,
                         input logic e_err);
    check({tag, " mem_cmd_valid"},    64'(mem_cmd_valid),    64'(e_mvalid));
    check({tag, " icache_cmd_ready"}, 64'(icache_cmd_ready), 64'(e_ic_rdy));
    check({tag, " dcache_cmd_ready"}, 64'(dcache_cmd_ready), 64'(e_dc_rdy));
    check({tag, " icache_rsp_valid"}, 64'(icache_rsp_valid), 64'(e_ic_rv));
    check({tag, " dcache_rsp_valid"}, 64'(dcache_rsp_valid), 64'(e_dc_rv));
    check({tag, " err_spurious_rsp"}, 64'(err_spurious_rsp), 64'(e_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Expected dcache-wins pattern for back-to-back contention.
  logic exp_d [4];

  initial begin
`ifdef SIMPLE_BUS_ARB_RR_EN
    exp_d = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    dcache_cmd_payload_wdata = 64'hCAFE_F00D_1234_5678;
    dcache_cmd_payload_wstrb = 8'hFF;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state: even with every request asserted, nothing is valid/ready.
    tick();
    set_in(1, 64'h4, 1, 64'h8, 0, 1, 1, 64'h1);
    #3;
    chk_ctl("reset", 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    //            ic_v ic_a                  dc_v dc_a     wen sz    rdy rsp rsp_d
    //            | mv maddr                 wen sz    icr dcr icv ic_d          dcv dc_d                  err
    tbl.push_back('{1, 64'h8000_0004,        0, 64'h0,   0, 3'd3, 1, 0, 64'h0,
                    1, 64'h8000_0004,        0, 3'd2, 1, 0, 0, 32'h0,        0, 64'h0,                 0});
    tbl.push_back('{0, 64'h0,                0, 64'h0,   0, 3'd3, 0, 0, 64'h0,
                    0, 64'h0,                0, 3'd0, 0, 0, 0, 32'h0,        0, 64'h0,                 0});
    tbl.push_back('{0, 64'h0,                0, 64'h0,   0, 3'd3, 0, 1, 64'h1111_2222_3333_4444,
                    0, 64'h0,                0, 3'd0, 0, 0, 1, 32'h1111_2222, 0, 64'h0,                 0});
    tbl.push_back('{0, 64'h0,                1, 64'h100, 0, 3'd3, 1, 0, 64'h0,
                    1, 64'h100,              0, 3'd3, 0, 1, 0, 32'h0,        0, 64'h0,                 0});
    tbl.push_back('{0, 64'h0,                0, 64'h0,   0, 3'd3, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD,
                    0, 64'h0,                0, 3'd0, 0, 0, 0, 32'h0,        1, 64'hAAAA_BBBB_CCCC_DDDD, 0});
    tbl.push_back('{1, 64'h4,                0, 64'h0,   0, 3'd3, 1, 0, 64'h0,
                    1, 64'h4,                0, 3'd2, 1, 0, 0, 32'h0,        0, 64'h0,                 0});
    tbl.push_back('{0, 64'h0,                1, 64'h8,   1, 3'd3, 1, 1, 64'hDEAD_BEEF_0BAD_F00D,
                    1, 64'h8,                1, 3'd3, 0, 1, 1, 32'hDEAD_BEEF, 0, 64'h0,                 0});
    tbl.push_back('{0, 64'h0,                0, 64'h0,   0, 3'd3, 0, 1, 64'h0123_4567_89AB_CDEF,
                    0, 64'h0,                0, 3'd0, 0, 0, 0, 32'h0,        1, 64'h0123_4567_89AB_CDEF, 0});
    tbl.push_back('{0, 64'h0,                1, 64'h200, 1, 3'd3, 1, 1, 64'h55,
                    1, 64'h200,              1, 3'd3, 0, 1, 0, 32'h0,        1, 64'h55,                0});
    tbl.push_back('{1, 64'h1000,             0, 64'h0,   0, 3'd3, 1, 1, 64'h9999_8888_7777_6666,
                    1, 64'h1000,             0, 3'd2, 1, 0, 1, 32'h7777_6666, 0, 64'h0,                 0});
    tbl.push_back('{0, 64'h0,                0, 64'h0,   0, 3'd3, 0, 1, 64'hFFFF,
                    0, 64'h0,                0, 3'd0, 0, 0, 0, 32'h0,        0, 64'h0,                 0});
    tbl.push_back('{0, 64'h0,                0, 64'h0,   0, 3'd3, 0, 0, 64'h0,
                    0, 64'h0,                0, 3'd0, 0, 0, 0, 32'h0,        0, 64'h0,                 1});
    tbl.push_back('{0, 64'h0,                0, 64'h0,   0, 3'd3, 1, 0, 64'h0,
                    0, 64'h0,                0, 3'd0, 0, 0, 0, 32'h0,        0, 64'h0,                 1});

    foreach (tbl[i]) begin
      tick();
      set_in(tbl[i].ic_v, tbl[i].ic_a, tbl[i].dc_v, tbl[i].dc_a, tbl[i].dc_wen,
             tbl[i].mready, tbl[i].rsp_v, tbl[i].rsp_d);
      dcache_cmd_payload_size = tbl[i].dc_size;
      #3;
      chk_ctl($sformatf("v%0d", i), tbl[i].e_mvalid, tbl[i].e_ic_rdy, tbl[i].e_dc_rdy,
              tbl[i].e_ic_rv, tbl[i].e_dc_rv, tbl[i].e_err);
      if (tbl[i].e_mvalid) begin
        check($sformatf("v%0d mem addr", i), mem_cmd_payload_addr, tbl[i].e_maddr);
        check($sformatf("v%0d mem wen", i),  64'(mem_cmd_payload_wen),  64'(tbl[i].e_mwen));
        check($sformatf("v%0d mem size", i), 64'(mem_cmd_payload_size), 64'(tbl[i].e_msize));
      end
      if (tbl[i].e_ic_rv)
        check($sformatf("v%0d icache data", i), 64'(icache_rsp_payload_data), 64'(tbl[i].e_ic_rd));
      if (tbl[i].e_dc_rv)
        check($sformatf("v%0d dcache data", i), dcache_rsp_payload_data, tbl[i].e_dc_rd);
    end

    // Contention: both request every cycle, memory answers one cycle later.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [63:0] d;
      tick();
      d = {32'h100 + 32'(k), 32'h200 + 32'(k)};
      set_in(k < 4, 64'h4, k < 4, 64'h10 + 64'(k * 8), 0, 1, k > 0, d);
      #3;
      if (k < 4) begin
        check($sformatf("arb%0d icache_ready", k), 64'(icache_cmd_ready), 64'(!exp_d[k]));
        check($sformatf("arb%0d dcache_ready", k), 64'(dcache_cmd_ready), 64'(exp_d[k]));
      end
      if (k > 0) begin
        check($sformatf("arb%0d icache_rsp", k), 64'(icache_rsp_valid), 64'(!exp_d[k-1]));
        check($sformatf("arb%0d dcache_rsp", k), 64'(dcache_rsp_valid), 64'(exp_d[k-1]));
        if (exp_d[k-1]) check($sformatf("arb%0d dcache data", k), dcache_rsp_payload_data, d);
        else            check($sformatf("arb%0d icache data", k), 64'(icache_rsp_payload_data), {32'h0, d[63:32]});
      end
    end

    // Lock: icache stalled by memory keeps the grant even when dcache joins.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      set_in(1, 64'h8000_0010, c > 0, 64'h20, 1, c == 3, 0, 0);
      #3;
      chk_ctl($sformatf("lock%0d", c), 1, c == 3, 0, 0, 0, 0);
      check($sformatf("lock%0d addr", c),  mem_cmd_payload_addr, 64'h8000_0010);
      check($sformatf("lock%0d wen", c),   64'(mem_cmd_payload_wen),   64'h0);
      check($sformatf("lock%0d wstrb", c), 64'(mem_cmd_payload_wstrb), 64'h0);
      check($sformatf("lock%0d wdata", c), mem_cmd_payload_wdata,      64'h0);
    end
    tick();
    set_in(1, 64'h8000_0010, 1, 64'h20, 1, 1, 0, 0);
    #3;
    chk_ctl("lock4", 1, 0, 1, 0, 0, 0);
    check("lock4 addr",  mem_cmd_payload_addr, 64'h20);
    check("lock4 wstrb", 64'(mem_cmd_payload_wstrb), 64'hFF);
    check("lock4 wdata", mem_cmd_payload_wdata, 64'hCAFE_F00D_1234_5678);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 64'hAAAA_0000_BBBB_1111);
    #3;
    chk_ctl("lock5", 0, 0, 0, 1, 0, 0);
    check("lock5 icache data", 64'(icache_rsp_payload_data), 64'hBBBB_1111);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 64'h7);
    #3;
    chk_ctl("lock6", 0, 0, 0, 0, 1, 0);

    // Full FIFO: four outstanding commands block the fifth until a pop.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      tick();
      set_in(0, 0, 1, 64'h40 + 64'(c * 8), 0, 1, c == 5, 64'h9);
      #3;
      chk_ctl($sformatf("full%0d", c), c != 4 && c != 5, 0, c != 4 && c != 5, 0, c == 5, 0);
    end

    // Reset with four outstanding: outputs idle, later responses are spurious.
    tick();
    reset = 1'b1;
    set_in(1, 64'h4, 1, 64'h8, 0, 1, 1, 64'h3);
    #3;
    chk_ctl("rstmid", 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1, 64'h3);
    #3;
    chk_ctl("post_rst rsp", 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk_ctl("post_rst err", 0, 0, 0, 0, 0, 1);
    tick();
    #3;
    chk_ctl("err sticky", 0, 0, 0, 0, 0, 1);
    do_reset();
    #3;
    chk_ctl("err cleared", 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
